// File: rtl/alu_pkg.sv
// Shared ALU control encodings and FSM state type for ALU-sharing logic.
package alu_pkg;

  localparam int CTR_W = 3;

  localparam logic [CTR_W-1:0] ALU_ADDU = 3'b000;
  localparam logic [CTR_W-1:0] ALU_ADD  = 3'b001;
  localparam logic [CTR_W-1:0] ALU_OR   = 3'b010;
  localparam logic [CTR_W-1:0] ALU_SUBU = 3'b100;
  localparam logic [CTR_W-1:0] ALU_SUB  = 3'b101;
  localparam logic [CTR_W-1:0] ALU_SLTU = 3'b110;
  localparam logic [CTR_W-1:0] ALU_SLT  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// On a tie the requester that did not win last time is granted.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  assign gnt_id = gnt[1];

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters.
// One op in flight: accept, execute, hold response until consumed.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [CTR_W-1:0] req0_ctr,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [CTR_W-1:0] req1_ctr,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_ovf,
  output logic             rsp_zero,
  output logic [CTR_W-1:0] alu_ctr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  input  logic             alu_zero
);

  import alu_pkg::*;

  state_e           r_state;
  state_e           w_next;
  logic             r_last_grant;
  logic             r_grant_id;
  logic [CTR_W-1:0] r_ctr;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_ovf;
  logic             r_zero;

  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_gnt_id;
  logic       w_idle;
  logic       w_accept;
  logic       w_rsp_ready;

  assign w_req = {req1_valid, req0_valid};

  rr_arb2 u_arb (
    .req        (w_req),
    .last_grant (r_last_grant),
    .gnt        (w_gnt),
    .gnt_id     (w_gnt_id)
  );

  // rst gates the readys so nothing is offered while reset is held
  assign w_idle      = (r_state == IDLE) && !rst;
  assign w_accept    = w_idle && (w_req != 2'b00);
  assign w_rsp_ready = r_grant_id ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (w_rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = w_idle && w_gnt[0];
    req1_ready = w_idle && w_gnt[1];
    rsp0_valid = (r_state == RESP) && !r_grant_id;
    rsp1_valid = (r_state == RESP) &&  r_grant_id;
    alu_ctr    = '0;
    alu_a      = '0;
    alu_b      = '0;
    if (r_state == EXEC) begin
      alu_ctr = r_ctr;
      alu_a   = r_a;
      alu_b   = r_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_ctr        <= '0;
      r_a          <= '0;
      r_b          <= '0;
    end else if (w_accept) begin
      r_last_grant <= w_gnt_id;
      r_grant_id   <= w_gnt_id;
      r_ctr        <= w_gnt_id ? req1_ctr : req0_ctr;
      r_a          <= w_gnt_id ? req1_a   : req0_a;
      r_b          <= w_gnt_id ? req1_b   : req0_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (r_state == EXEC) begin
      r_result <= alu_result;
      r_ovf    <= alu_overflow;
      r_zero   <= alu_zero;
    end
  end

  assign rsp_result = r_result;
  assign rsp_ovf    = r_ovf;
  assign rsp_zero   = r_zero;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with a behavioural ALU.
// Table-driven single ops plus tie, alternation and reset sequences.
module tb_alu_share_arbiter;

  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_ctr, req1_ctr;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready, rsp1_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_ovf, rsp_zero;
  logic [2:0]   alu_ctr;
  logic [W-1:0] alu_a, alu_b;
  logic [W-1:0] alu_result;
  logic         alu_overflow, alu_zero;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(W), .CTR_W(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_ctr(req0_ctr), .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_ctr(req1_ctr), .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero),
    .alu_ctr(alu_ctr), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero)
  );

  // Reference ALU: overflow only reported by trapping ADD/SUB
  always_comb begin
    alu_result   = '0;
    alu_overflow = 1'b0;
    case (alu_ctr)
      ALU_ADDU: alu_result = alu_a + alu_b;
      ALU_ADD: begin
        alu_result   = alu_a + alu_b;
        alu_overflow = (alu_a[31] == alu_b[31]) &&
                       (alu_result[31] != alu_a[31]);
      end
      ALU_OR:   alu_result = alu_a | alu_b;
      ALU_SUBU: alu_result = alu_a - alu_b;
      ALU_SUB: begin
        alu_result   = alu_a - alu_b;
        alu_overflow = (alu_a[31] != alu_b[31]) &&
                       (alu_result[31] != alu_a[31]);
      end
      ALU_SLTU: alu_result = {31'd0, alu_a < alu_b};
      ALU_SLT:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default:  alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input int who, input logic [2:0] ctr,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    if (who == 1) begin
      req1_ctr = ctr; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end else begin
      req0_ctr = ctr; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end
  endtask

  // Expects to be called right after an edge; returns 1ns after the
  // handshake edge so the following IDLE cycle is still observable.
  task automatic complete(input int who, input logic [2:0] ctr,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] res, input logic ovf,
                          input logic zero, input int bp,
                          input string nm);
    int   n;
    logic got;
    logic [1:0] vexp;
    n    = 0;
    got  = 1'b0;
    vexp = (who == 1) ? 2'b10 : 2'b01;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      got = (who == 1) ? req1_ready : req0_ready;
    end
    chk({nm, "/accept"}, W'(got), W'(1));
    if (!got) return;
    chk({nm, "/other_ready"},
        W'((who == 1) ? req0_ready : req1_ready), W'(0));
    chk({nm, "/idle_alu_a"}, alu_a, '0);
    @(posedge clk);
    #1;
    if (who == 1) begin
      req1_valid = 1'b0; req1_a = ~a; req1_b = ~b;
    end else begin
      req0_valid = 1'b0; req0_a = ~a; req0_b = ~b;
    end
    @(negedge clk);
    chk({nm, "/exec_ctr"}, W'(alu_ctr), W'(ctr));
    chk({nm, "/exec_a"}, alu_a, a);
    chk({nm, "/exec_b"}, alu_b, b);
    chk({nm, "/exec_valid"}, W'({rsp1_valid, rsp0_valid}), W'(0));
    chk({nm, "/exec_ready"}, W'({req1_ready, req0_ready}), W'(0));
    @(negedge clk);
    chk({nm, "/rsp_valid"}, W'({rsp1_valid, rsp0_valid}), W'(vexp));
    chk({nm, "/result"}, rsp_result, res);
    chk({nm, "/ovf"}, W'(rsp_ovf), W'(ovf));
    chk({nm, "/zero"}, W'(rsp_zero), W'(zero));
    for (int i = 0; i < bp; i++) begin
      if (who == 1) rsp0_ready = 1'b1;
      else          rsp1_ready = 1'b1;
      @(negedge clk);
      chk({nm, "/bp_valid"}, W'({rsp1_valid, rsp0_valid}), W'(vexp));
      chk({nm, "/bp_result"}, rsp_result, res);
      chk({nm, "/bp_ready"}, W'({req1_ready, req0_ready}), W'(0));
    end
    rsp0_ready = (who == 0);
    rsp1_ready = (who == 1);
    @(posedge clk);
    #1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    chk({nm, "/done_valid"}, W'({rsp1_valid, rsp0_valid}), W'(0));
  endtask

  typedef struct {
    int         who;
    logic [2:0] ctr;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic       ovf;
    logic       zero;
    int         bp;
    string      nm;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{0, ALU_ADDU, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 0, "addu0"};
    vecs[1] = '{1, ALU_SUBU, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 5, "subu_z"};
    vecs[2] = '{1, ALU_ADDU, 32'd1, 32'd0, 32'd1, 1'b0, 1'b0, 0, "addu_nz"};
    vecs[3] = '{0, ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000,
                1'b1, 1'b0, 0, "add_ovf"};
    vecs[4] = '{1, ALU_ADDU, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000,
                1'b0, 1'b0, 0, "addu_noovf"};
    vecs[5] = '{0, ALU_OR, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F,
                1'b0, 1'b0, 0, "or"};
    vecs[6] = '{1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1,
                1'b0, 1'b0, 0, "slt"};
    vecs[7] = '{0, ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0,
                1'b0, 1'b1, 0, "sltu"};
    vecs[8] = '{1, ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE,
                1'b0, 1'b0, 0, "sub_neg"};
    vecs[9] = '{0, ALU_SUBU, 32'd0, 32'd1, 32'hFFFF_FFFF,
                1'b0, 1'b0, 2, "subu_wrap"};

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_ctr = '0; req0_a = '0; req0_b = '0;
    req1_ctr = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Both requesters valid from reset
    issue(0, ALU_SUB, 32'h8000_0000, 32'd1);
    issue(1, ALU_ADDU, 32'd3, 32'd3);
    #12;
    chk("rst/ready", W'({req1_ready, req0_ready}), W'(0));
    chk("rst/valid", W'({rsp1_valid, rsp0_valid}), W'(0));
    chk("rst/result", rsp_result, '0);
    chk("rst/flags", W'({rsp_ovf, rsp_zero}), W'(0));
    chk("rst/alu", W'({alu_ctr, alu_a | alu_b}), W'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    complete(0, ALU_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF,
             1'b1, 1'b0, 0, "tie_r0");
    complete(1, ALU_ADDU, 32'd3, 32'd3, 32'd6, 1'b0, 1'b0, 3, "tie_r1");

    // Alternation with both requesters continuously busy
    issue(0, ALU_ADDU, 32'd2, 32'd2);
    issue(1, ALU_OR, 32'h10, 32'h01);
    complete(0, ALU_ADDU, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 0, "alt_a0");
    issue(0, ALU_ADDU, 32'd7, 32'd8);
    complete(1, ALU_OR, 32'h10, 32'h01, 32'h11, 1'b0, 1'b0, 0, "alt_b1");
    complete(0, ALU_ADDU, 32'd7, 32'd8, 32'd15, 1'b0, 1'b0, 0, "alt_c0");

    // Reset while an op from requester 0 is executing
    issue(0, ALU_ADDU, 32'd10, 32'd20);
    @(negedge clk);
    chk("mid/accept", W'(req0_ready), W'(1));
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid/ready", W'({req1_ready, req0_ready}), W'(0));
    chk("mid/alu_a", alu_a, '0);
    chk("mid/result", rsp_result, '0);
    @(negedge clk);
    chk("mid/valid", W'({rsp1_valid, rsp0_valid}), W'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(1, ALU_SUBU, 32'd9, 32'd9);
    issue(0, ALU_ADDU, 32'd1, 32'd0);
    complete(0, ALU_ADDU, 32'd1, 32'd0, 32'd1, 1'b0, 1'b0, 0, "post_r0");
    complete(1, ALU_SUBU, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 0, "post_r1");

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].who, vecs[i].ctr, vecs[i].a, vecs[i].b);
      complete(vecs[i].who, vecs[i].ctr, vecs[i].a, vecs[i].b,
               vecs[i].res, vecs[i].ovf, vecs[i].zero, vecs[i].bp,
               vecs[i].nm);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
